// File: rtl/mixer_pkg.sv
// mixer_pkg: shared state encoding and width derivations for the stereo mixer.
package mixer_pkg;
    typedef enum logic [1:0] {IDLE, ACC, SCALE, HOLD} state_t;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int acc_width(input int nch, input int in_w);
        return clog2(nch * ((1 << in_w) - 1) + 1);
    endfunction
    // vol+1 needs one bit more than vol itself
    function automatic int prod_width(input int acc_w, input int vol_w);
        return acc_w + vol_w + 1;
    endfunction
    localparam int ACC_W = acc_width(4, 4);
    localparam int PROD_W = prod_width(ACC_W, 3);
endpackage

// File: rtl/mixer_scale_sat.sv
// mixer_scale_sat: multiplies an accumulated sum by (vol+1) at full width and
// saturates the product to the output range.
module mixer_scale_sat
    import mixer_pkg::*;
#(
    parameter int ACC_W = 6,
    parameter int VOL_W = 3,
    parameter int OUT_W = 9
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [VOL_W-1:0] vol,
    output logic [OUT_W-1:0] res
);
    localparam int PW = prod_width(ACC_W, VOL_W);
    localparam int W = PW > OUT_W ? PW : OUT_W;
    logic [W-1:0] prod;
    logic [W-1:0] lim;
    assign prod = W'(acc) * (W'(vol) + W'(1));
    assign lim = W'({OUT_W{1'b1}});
    assign res = prod > lim ? {OUT_W{1'b1}} : prod[OUT_W-1:0];
endmodule

// File: rtl/mixer_seq.sv
// mixer_seq: time-multiplexed stereo mixer; serially accumulates latched channels,
// scales by master volume and hands the L/R pair downstream over valid/ready.
module mixer_seq
    import mixer_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IN_W = 4,
    parameter int VOL_W = 3,
    parameter int OUT_W = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic [NCH*IN_W-1:0]   ch_in,
    input  logic [NCH-1:0]        en_l,
    input  logic [NCH-1:0]        en_r,
    input  logic [VOL_W-1:0]      vol_l,
    input  logic [VOL_W-1:0]      vol_r,
    output logic [OUT_W-1:0]      out_l,
    output logic [OUT_W-1:0]      out_r,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  clr_overrun
);
    localparam int AW = acc_width(NCH, IN_W);
    localparam int IW = NCH > 1 ? clog2(NCH) : 1;
    state_t state;
    logic [IN_W-1:0] ch_q [NCH];
    logic [NCH-1:0] en_l_q, en_r_q;
    logic [VOL_W-1:0] vol_l_q, vol_r_q;
    logic [AW-1:0] acc_l, acc_r;
    logic [IW-1:0] idx;
    logic [OUT_W-1:0] sat_l, sat_r;
    logic accept, drop;
    // A tick is only taken when the output slot is free or being vacated this cycle
    assign accept = tick & (state == IDLE | (state == HOLD & out_ready));
    assign drop = tick & ~accept;
    assign busy = state != IDLE;
    mixer_scale_sat #(.ACC_W(AW), .VOL_W(VOL_W), .OUT_W(OUT_W)) u_sat_l (
        .acc(acc_l), .vol(vol_l_q), .res(sat_l));
    mixer_scale_sat #(.ACC_W(AW), .VOL_W(VOL_W), .OUT_W(OUT_W)) u_sat_r (
        .acc(acc_r), .vol(vol_r_q), .res(sat_r));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            out_l <= '0;
            out_r <= '0;
            out_valid <= 1'b0;
            overrun <= 1'b0;
            acc_l <= '0;
            acc_r <= '0;
            idx <= '0;
            en_l_q <= '0;
            en_r_q <= '0;
            vol_l_q <= '0;
            vol_r_q <= '0;
            for (int k = 0; k < NCH; k++) ch_q[k] <= '0;
        end else begin
            overrun <= drop | (overrun & ~clr_overrun);
            if (accept) begin
                for (int k = 0; k < NCH; k++) ch_q[k] <= ch_in[k*IN_W +: IN_W];
                en_l_q <= en_l;
                en_r_q <= en_r;
                vol_l_q <= vol_l;
                vol_r_q <= vol_r;
                acc_l <= '0;
                acc_r <= '0;
                idx <= '0;
                out_valid <= 1'b0;
                state <= ACC;
            end else begin
                case (state)
                    ACC: begin
                        acc_l <= acc_l + (en_l_q[idx] ? AW'(ch_q[idx]) : '0);
                        acc_r <= acc_r + (en_r_q[idx] ? AW'(ch_q[idx]) : '0);
                        idx <= idx + IW'(1);
                        if (idx == IW'(NCH - 1)) state <= SCALE;
                    end
                    SCALE: begin
                        out_l <= sat_l;
                        out_r <= sat_r;
                        out_valid <= 1'b1;
                        state <= HOLD;
                    end
                    HOLD: if (out_ready) begin
                        out_valid <= 1'b0;
                        state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mixer_seq.sv
// tb_mixer_seq: directed checks of the stereo mixer, including an OUT_W=8 instance
// that exercises output saturation.
module tb_mixer_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic [15:0] ch_in = '0;
    logic [3:0] en_l = '0, en_r = '0;
    logic [2:0] vol_l = '0, vol_r = '0;
    logic out_ready = 1'b1;
    logic clr_overrun = 1'b0;
    logic [8:0] out_l, out_r;
    logic [7:0] out8_l, out8_r;
    logic out_valid, busy, overrun;
    logic out8_valid, busy8, overrun8;
    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    mixer_seq #(.NCH(4), .IN_W(4), .VOL_W(3), .OUT_W(9)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .ch_in(ch_in), .en_l(en_l), .en_r(en_r),
        .vol_l(vol_l), .vol_r(vol_r), .out_l(out_l), .out_r(out_r), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun));

    mixer_seq #(.NCH(4), .IN_W(4), .VOL_W(3), .OUT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .ch_in(ch_in), .en_l(en_l), .en_r(en_r),
        .vol_l(vol_l), .vol_r(vol_r), .out_l(out8_l), .out_r(out8_r), .out_valid(out8_valid),
        .out_ready(out_ready), .busy(busy8), .overrun(overrun8), .clr_overrun(clr_overrun));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge: pulses tick and counts rising edges until out_valid appears
    task automatic run_tick(input bit chg, input logic [15:0] alt, output int l);
        tick = 1'b1;
        l = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            tick = 1'b0;
            if (chg && c == 1) ch_in = alt;
            if (out_valid) begin
                l = c;
                break;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out_l", 32'(out_l), 0);
        chk("rst_out_r", 32'(out_r), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // full scale: 60*8 = 480, saturates to 255 at OUT_W=8
        ch_in = 16'hFFFF; en_l = 4'hF; en_r = 4'hF; vol_l = 3'd7; vol_r = 3'd7;
        run_tick(1'b0, '0, lat);
        chk("t1_latency", 32'(lat), 6);
        chk("t1_out_l", 32'(out_l), 480);
        chk("t1_out_r", 32'(out_r), 480);
        chk("t3_sat_l", 32'(out8_l), 255);
        chk("t3_sat_r", 32'(out8_r), 255);
        @(negedge clk);
        chk("t1_valid_one_cycle", 32'(out_valid), 0);
        chk("t1_idle", 32'(busy), 0);

        // pan split: L=3+7 at gain 1, R=(5+9)*3
        ch_in = 16'h9753; en_l = 4'b0101; en_r = 4'b1010; vol_l = 3'd0; vol_r = 3'd2;
        run_tick(1'b0, '0, lat);
        chk("t2_latency", 32'(lat), 6);
        chk("t2_out_l", 32'(out_l), 10);
        chk("t2_out_r", 32'(out_r), 42);
        @(negedge clk);

        // backpressure with a dropped tick in HOLD
        out_ready = 1'b0;
        run_tick(1'b0, '0, lat);
        chk("t4_latency", 32'(lat), 6);
        ch_in = 16'hFFFF;
        repeat (2) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_hold_valid", 32'(out_valid), 1);
        chk("t4_hold_l", 32'(out_l), 10);
        chk("t4_hold_r", 32'(out_r), 42);
        chk("t4_overrun_set", 32'(overrun), 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_handshake_valid", 32'(out_valid), 0);
        chk("t4_handshake_idle", 32'(busy), 0);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        chk("t4_overrun_clr", 32'(overrun), 0);
        tick = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        clr_overrun = 1'b0;
        chk("t4_set_wins", 32'(overrun), 1);
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        chk("t4_drain", 32'(busy), 0);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        chk("t4_overrun_clr2", 32'(overrun), 0);

        // tick coinciding with the accepting handshake in HOLD
        ch_in = 16'h9753; en_l = 4'b0101; en_r = 4'b1010; vol_l = 3'd0; vol_r = 3'd2;
        out_ready = 1'b0;
        run_tick(1'b0, '0, lat);
        chk("t5_first_latency", 32'(lat), 6);
        out_ready = 1'b1;
        ch_in = 16'h4321; en_l = 4'hF; en_r = 4'hF; vol_l = 3'd1; vol_r = 3'd0;
        run_tick(1'b0, '0, lat);
        chk("t5_latency", 32'(lat), 6);
        chk("t5_out_l", 32'(out_l), 20);
        chk("t5_out_r", 32'(out_r), 10);
        chk("t5_no_overrun", 32'(overrun), 0);
        @(negedge clk);

        // reset during ACC, then a mix whose ch_in changes mid-accumulation
        ch_in = 16'hFFFF; en_l = 4'hF; en_r = 4'hF; vol_l = 3'd7; vol_r = 3'd7;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        chk("t6_in_acc", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_out_l", 32'(out_l), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ch_in = 16'h4321; vol_l = 3'd1; vol_r = 3'd0;
        run_tick(1'b1, 16'hFFFF, lat);
        chk("t6_latency", 32'(lat), 6);
        chk("t6_out_l", 32'(out_l), 20);
        chk("t6_out_r", 32'(out_r), 10);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
